sdio_master: RTL and testbench

- Parametrised 3-wire serial master (sclk plus one bidirectional sdio) with a proper tristate split: sdio_o, sdio_oe and sdio_i.
- Converts a single-request valid/ready transaction into a serial write frame or read frame.
- Read frames include a programmable bus turnaround, so the slave can drive sdio back without contention.
- Sits between the register-access sequencer and the pad; the top level builds the tristate as: sdio = sdio_oe ? sdio_o : 'z.

---
 rtl/sdio_master.sv | 121 ++++++++++++
 tb/tb_sdio_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdio_master.sv
// 3-wire serial master: turns one valid/ready request into a write or read frame
// on sclk/sdio, with a released-bus turnaround ahead of read data.
module sdio_master #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int CLK_DIV     = 2,
    parameter int TURN_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              sclk,
    output logic              sdio_o,
    output logic              sdio_oe,
    input  logic              sdio_i,
    output logic              busy
);

    localparam int NW = 1 + ADDR_W + DATA_W;
    localparam int NR = 1 + ADDR_W + TURN_CYCLES + DATA_W;
    localparam int BW = $clog2(NR + 1);
    localparam int HW = $clog2(CLK_DIV) + 1;
    localparam int SW = ADDR_W + DATA_W;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CMD   = 3'd1;
    localparam logic [2:0] WDATA = 3'd2;
    localparam logic [2:0] TURN  = 3'd3;
    localparam logic [2:0] RDATA = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]        state;
    logic [HW-1:0]     hcnt;
    logic [BW-1:0]     bitcnt;
    logic [SW-1:0]     txsh;
    logic [DATA_W-1:0] rxsh;
    logic              rw;

    logic [BW-1:0] bitnxt;
    logic [BW-1:0] blast;
    logic          hlast;

    assign bitnxt    = bitcnt + BW'(1);
    assign blast     = rw ? BW'(NR) : BW'(NW);
    assign hlast     = (hcnt == HW'(CLK_DIV - 1));
    assign req_ready = (state == IDLE);
    assign busy      = ~req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hcnt      <= '0;
            bitcnt    <= '0;
            txsh      <= '0;
            rxsh      <= '0;
            rw        <= 1'b0;
            sclk      <= 1'b0;
            sdio_o    <= 1'b0;
            sdio_oe   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        // rw bit goes out immediately; the shifter holds address then data
                        state   <= CMD;
                        rw      <= req_rw;
                        txsh    <= {req_addr, req_wdata};
                        sdio_o  <= req_rw;
                        sdio_oe <= 1'b1;
                        sclk    <= 1'b0;
                        hcnt    <= '0;
                        bitcnt  <= '0;
                    end
                end
                DONE: state <= IDLE;
                default: begin
                    if (!hlast) begin
                        hcnt <= hcnt + HW'(1);
                    end else begin
                        hcnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                            if (state == RDATA)
                                rxsh <= DATA_W'({rxsh, sdio_i});
                        end else begin
                            // end of a bit period: the next bit is driven as sclk falls
                            sclk   <= 1'b0;
                            bitcnt <= bitnxt;
                            if (bitnxt == blast) begin
                                state     <= DONE;
                                sdio_o    <= 1'b0;
                                sdio_oe   <= 1'b0;
                                rsp_valid <= 1'b1;
                                if (rw)
                                    rsp_rdata <= rxsh;
                            end else if (bitnxt <= BW'(ADDR_W) || !rw) begin
                                state  <= (bitnxt <= BW'(ADDR_W)) ? CMD : WDATA;
                                sdio_o <= txsh[SW-1];
                                txsh   <= txsh << 1;
                            end else begin
                                state   <= (bitnxt <= BW'(ADDR_W + TURN_CYCLES)) ? TURN : RDATA;
                                sdio_o  <= 1'b0;
                                sdio_oe <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdio_master.sv
// Bench for sdio_master: two instances (default and swept parameters), a slave model
// that answers reads, and a frame-level reference model checked per transaction.
module tb_sdio_master;

    localparam int AW [2] = '{7, 15};
    localparam int DW [2] = '{8, 16};
    localparam int CD [2] = '{2, 1};
    localparam int TC [2] = '{1, 2};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        rv   [2];
    logic        rrw  [2];
    logic [15:0] ra   [2];
    logic [15:0] rwd  [2];
    logic        rdy  [2];
    logic        rsp  [2];
    logic        sclk_w [2];
    logic        o_w  [2];
    logic        oe_w [2];
    logic        busy_w [2];
    logic        si   [2];
    logic [7:0]  rd_a;
    logic [15:0] rd_b;

    sdio_master u_a (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(rdy[0]), .req_rw(rrw[0]),
        .req_addr(ra[0][6:0]), .req_wdata(rwd[0][7:0]), .rsp_valid(rsp[0]), .rsp_rdata(rd_a),
        .sclk(sclk_w[0]), .sdio_o(o_w[0]), .sdio_oe(oe_w[0]), .sdio_i(si[0]), .busy(busy_w[0])
    );

    sdio_master #(.ADDR_W(15), .DATA_W(16), .CLK_DIV(1), .TURN_CYCLES(2)) u_b (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(rdy[1]), .req_rw(rrw[1]),
        .req_addr(ra[1][14:0]), .req_wdata(rwd[1][15:0]), .rsp_valid(rsp[1]), .rsp_rdata(rd_b),
        .sclk(sclk_w[1]), .sdio_o(o_w[1]), .sdio_oe(oe_w[1]), .sdio_i(si[1]), .busy(busy_w[1])
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint unsigned rdat(input int i);
        return (i == 1) ? longint'(rd_b) : longint'(rd_a);
    endfunction

    // slave / monitor state, all advanced on the falling clk edge
    logic [15:0]     srd    [2];
    logic            sd_oe  [2];
    logic            sd_bit [2];
    logic            junk   [2];
    logic            psclk  [2];
    logic            po     [2];
    logic            rwb    [2];
    int              cyc    [2];
    int              oec    [2];
    int              rise   [2];
    int              lastr  [2];
    longint unsigned bits   [2];
    longint unsigned oeb    [2];
    int              s_oec  [2];
    int              s_rise [2];
    longint unsigned s_bits [2];
    longint unsigned s_oeb  [2];
    int              nrsp   [2];
    int              cont   [2];
    int              glitch [2];
    int              badper [2];
    int              idlebad[2];
    longint unsigned exp_rd [2];

    assign si[0] = sd_oe[0] ? sd_bit[0] : junk[0];
    assign si[1] = sd_oe[1] ? sd_bit[1] : junk[1];

    initial begin
        for (int i = 0; i < 2; i++) begin
            rv[i] = 0; rrw[i] = 0; ra[i] = 0; rwd[i] = 0; srd[i] = 0;
            sd_oe[i] = 0; sd_bit[i] = 0; junk[i] = 0; psclk[i] = 0; po[i] = 0; rwb[i] = 0;
            cyc[i] = 0; oec[i] = 0; rise[i] = 0; lastr[i] = 0; bits[i] = 0; oeb[i] = 0;
            s_oec[i] = 0; s_rise[i] = 0; s_bits[i] = 0; s_oeb[i] = 0; nrsp[i] = 0;
            cont[i] = 0; glitch[i] = 0; badper[i] = 0; idlebad[i] = 0; exp_rd[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int d0;
            d0 = 1 + AW[i] + TC[i];
            if (oe_w[i] && sd_oe[i]) cont[i]++;
            if (!busy_w[i]) begin
                if (sclk_w[i] || oe_w[i] || o_w[i]) idlebad[i]++;
                cyc[i] = 0; oec[i] = 0; rise[i] = 0; bits[i] = 0; oeb[i] = 0;
                sd_oe[i] = 0; rwb[i] = 0;
            end else begin
                cyc[i]++;
                if (oe_w[i]) oec[i]++;
                if (sclk_w[i] && !psclk[i]) begin
                    if (rise[i] > 0 && cyc[i] - lastr[i] != 2 * CD[i]) badper[i]++;
                    if (rise[i] == 0) rwb[i] = o_w[i];
                    rise[i]++;
                    lastr[i] = cyc[i];
                    bits[i] = (bits[i] << 1) | longint'(o_w[i]);
                    oeb[i]  = (oeb[i] << 1) | longint'(oe_w[i]);
                end
                if (sclk_w[i] && psclk[i] && o_w[i] != po[i]) glitch[i]++;
                if (!sclk_w[i] && psclk[i]) begin
                    if (cyc[i] - lastr[i] != CD[i]) badper[i]++;
                    // slave drives read data only after the master's turnaround has elapsed
                    if (rwb[i] && rise[i] >= d0 && rise[i] < d0 + DW[i]) begin
                        sd_oe[i]  = 1;
                        sd_bit[i] = srd[i][DW[i] - 1 - (rise[i] - d0)];
                    end else begin
                        sd_oe[i] = 0;
                    end
                end
                if (rsp[i]) begin
                    s_oec[i] = oec[i]; s_rise[i] = rise[i]; s_bits[i] = bits[i]; s_oeb[i] = oeb[i];
                    nrsp[i]++;
                end
            end
            psclk[i] = sclk_w[i];
            po[i]    = o_w[i];
            junk[i]  = 1'($urandom_range(0, 1));
        end
    end

    // one full transaction on instance i, checked against the frame rules
    task automatic txn(input int i, input bit rw, input longint unsigned addr,
                       input longint unsigned wdata, input longint unsigned rdv);
        int n, k;
        longint unsigned amask, dmask;
        amask = (64'd1 << AW[i]) - 1;
        dmask = (64'd1 << DW[i]) - 1;
        addr  = addr & amask;
        wdata = wdata & dmask;
        rdv   = rdv & dmask;
        n = rw ? 1 + AW[i] + TC[i] + DW[i] : 1 + AW[i] + DW[i];
        srd[i] = 16'(rdv);
        @(negedge clk);
        rrw[i] = rw; ra[i] = 16'(addr); rwd[i] = 16'(wdata); rv[i] = 1;
        k = 0;
        while (!rdy[i] && k < 300) begin @(negedge clk); k++; end
        if (!rdy[i]) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        rv[i] = 0; rrw[i] = 1'($urandom); ra[i] = 16'($urandom); rwd[i] = 16'($urandom);
        k = 0;
        do begin @(negedge clk); k++; end while (!rsp[i] && k < 400);
        chk($sformatf("latency%0d", i), k, n * 2 * CD[i] + 1);
        chk($sformatf("done_sclk%0d", i), sclk_w[i], 0);
        chk($sformatf("done_oe%0d", i), oe_w[i], 0);
        @(posedge clk);
        #1;
        chk($sformatf("sclk_periods%0d", i), s_rise[i], n);
        if (!rw) begin
            chk($sformatf("wframe%0d", i), s_bits[i], (addr << DW[i]) | wdata);
            chk($sformatf("woe_bits%0d", i), s_oeb[i], (64'd1 << n) - 1);
            chk($sformatf("woe_cycles%0d", i), s_oec[i], n * 2 * CD[i]);
        end else begin
            exp_rd[i] = rdv;
            chk($sformatf("rcmd%0d", i), s_bits[i] >> (TC[i] + DW[i]), (64'd1 << AW[i]) | addr);
            chk($sformatf("roe_bits%0d", i), s_oeb[i], ((64'd1 << (1 + AW[i])) - 1) << (TC[i] + DW[i]));
            chk($sformatf("roe_cycles%0d", i), s_oec[i], (1 + AW[i]) * 2 * CD[i]);
        end
        chk($sformatf("rdata%0d", i), rdat(i), exp_rd[i]);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n0;
        longint unsigned a2, rdv;
        #22;
        chk("rst_ready", rdy[0], 1);
        chk("rst_busy", busy_w[0], 0);
        chk("rst_rsp", rsp[0], 0);
        chk("rst_rdata", rd_a, 0);
        chk("rst_sclk", sclk_w[0], 0);
        chk("rst_sdio", {oe_w[0], o_w[0]}, 0);
        chk("rst_rdata_b", rd_b, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);

        // directed write and read on the default instance
        txn(0, 0, 'h15, 'hA5, 'h00);
        txn(0, 1, 'h03, 'h00, 'h5A);

        // back-to-back: write then read with req_valid held high
        n0 = nrsp[0];
        a2 = $urandom & 'h7F;
        rdv = $urandom & 'hFF;
        srd[0] = 16'(rdv);
        @(negedge clk);
        rrw[0] = 0; ra[0] = 16'h2A; rwd[0] = 16'h3C; rv[0] = 1;
        @(posedge clk);
        #1;
        rrw[0] = 1; ra[0] = 16'(a2);
        k = 0;
        do begin @(negedge clk); k++; end while (!rsp[0] && k < 400);
        chk("b2b_lat1", k, 65);
        chk("b2b_rdata1", rd_a, exp_rd[0]);
        @(negedge clk);
        chk("b2b_gap_ready", rdy[0], 1);
        chk("b2b_gap_sclk", sclk_w[0], 0);
        @(posedge clk);
        #1;
        rv[0] = 0;
        k = 0;
        do begin @(negedge clk); k++; end while (!rsp[0] && k < 400);
        chk("b2b_lat2", k, 69);
        @(posedge clk);
        #1;
        exp_rd[0] = rdv;
        chk("b2b_rdata2", rd_a, rdv);
        chk("b2b_rcmd", s_bits[0] >> 9, 'h80 | a2);
        chk("b2b_pulses", nrsp[0] - n0, 2);

        // reset during the 5th address bit of a read
        n0 = nrsp[0];
        @(negedge clk);
        rrw[0] = 1; ra[0] = 16'h55; rv[0] = 1;
        @(posedge clk);
        #1;
        rv[0] = 0;
        repeat (22) @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("mid_rst_sclk", sclk_w[0], 0);
        chk("mid_rst_oe", oe_w[0], 0);
        chk("mid_rst_ready", rdy[0], 1);
        repeat (3) @(negedge clk);
        rst_n = 1;
        exp_rd[0] = 0;
        exp_rd[1] = 0;
        repeat (5) @(negedge clk);
        chk("mid_rst_no_rsp", nrsp[0] - n0, 0);
        txn(0, 1, 'h41, 'h00, 'hC3);

        // swept-parameter instance
        txn(1, 1, $urandom, 0, 'hBEEF);
        txn(1, 0, $urandom, $urandom, 0);

        // random traffic on both instances in parallel
        fork
            begin
                repeat (500) txn(0, 1'($urandom), $urandom, $urandom, $urandom);
            end
            begin
                repeat (500) txn(1, 1'($urandom), $urandom, $urandom, $urandom);
            end
        join

        for (int i = 0; i < 2; i++) begin
            chk($sformatf("contention%0d", i), cont[i], 0);
            chk($sformatf("sdio_change_high%0d", i), glitch[i], 0);
            chk($sformatf("sclk_period%0d", i), badper[i], 0);
            chk($sformatf("idle_outputs%0d", i), idlebad[i], 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end

endmodule
